fphub_acc_initiator: RTL and testbench

- Sequential initiator for the FPHUB adder's start/finish interface.
- Accepts a stream of FPHUB operands on a valid/ready input and accumulates them through one external adder instance, one operation at a time. Holds the adder operands and start stable until finish.
- When the operand flagged last has been added, presents the running sum and operand count on a valid/ready output.
- Sits between a data source and the adder; the adder is instantiated beside it at the same level.

---
 rtl/fphub_pkg.sv | 31 +++
 rtl/fphub_acc_initiator.sv | 137 +++++++++++++
 tb/tb_fphub_acc_initiator.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fphub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fphub_pkg                                                  |
// | Brief   : Shared types, default widths and helpers for FPHUB blocks. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package fphub_pkg;

  localparam int M_DEF = 23;
  localparam int E_DEF = 8;

  // Sequencing states of the accumulating initiator
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fphub_state_e;

  // FPHUB zero is the all-zero word: sign, exponent and mantissa all clear.
  function automatic logic [63:0] fphub_zero(input int e, input int m);
    logic [63:0] z;
    z = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < e + m + 1) z[i] = 1'b0;
    end
    return z;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fphub_acc_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fphub_acc_initiator                                        |
// | Brief   : Streams FPHUB operands through one external start/finish   |
// |           adder, one addition at a time, and presents the running    |
// |           sum and operand count once the last operand is added.      |
// | Options : FPHUB_ACC_TIMEOUT_EN adds a WAIT watchdog and err output.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fphub_acc_initiator
  import fphub_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int E       = E_DEF,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [E+M:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             add_start,
  output logic [E+M:0]     add_x,
  output logic [E+M:0]     add_y,
  input  logic             add_finish,
  input  logic [E+M:0]     add_z,
  output logic             out_valid,
  output logic [E+M:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready,
`ifdef FPHUB_ACC_TIMEOUT_EN
  output logic             err,
`endif
  output logic             busy
);

  localparam int              c_width     = E + M + 1;
  localparam logic [63:0]     c_zero_wide = fphub_zero(E, M);
  localparam logic [E+M:0]    c_zero      = c_zero_wide[E+M:0];

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       r_state;
  logic [E+M:0]     r_acc;
  logic [E+M:0]     r_opnd;
  logic [E+M:0]     r_add_x;
  logic             r_last;
  logic [CNT_W-1:0] r_count;
  logic             w_timeout;

`ifdef FPHUB_ACC_TIMEOUT_EN
  localparam int c_wdog_w = $clog2(TIMEOUT + 1);

  logic [c_wdog_w-1:0] r_wdog;
  logic                r_err;

  // Watchdog: counts WAIT cycles, cleared whenever not waiting so it starts
  // from zero on each entry into WAIT. err is sticky until the DONE handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_WAIT) r_wdog <= r_wdog + c_wdog_w'(1);
      else                   r_wdog <= '0;
      if (w_timeout && !add_finish)                r_err <= 1'b1;
      else if (r_state == S_DONE && out_ready)     r_err <= 1'b0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wdog == c_wdog_w'(TIMEOUT - 1));
  assign err       = r_err;
`else
  wire w_unused_timeout = (TIMEOUT != 0) && (c_width != 0);
  assign w_timeout = 1'b0;
`endif

  // Operand sequencing: accept, issue to the adder, wait for finish, present.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= c_zero;
      r_opnd  <= c_zero;
      r_add_x <= c_zero;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_opnd  <= in_data;
            r_last  <= in_last;
            // acc cannot change before this addition completes, so capture
            // it now to keep add_x frozen for the whole start window.
            r_add_x <= r_acc;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (add_finish) begin
            r_acc <= add_z;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
            r_state <= r_last ? S_DONE : S_IDLE;
          end else if (w_timeout) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            r_acc   <= c_zero;
            r_count <= '0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign add_start = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign add_x     = r_add_x;
  assign add_y     = r_opnd;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_acc;
  assign out_count = r_count;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fphub_acc_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fphub_acc_initiator                                     |
// | Brief   : Randomized self-checking bench with an integer-sum adder   |
// |           model and a stream-level reference accumulator.            |
// | Options : FPHUB_ACC_TIMEOUT_EN enables the watchdog scenario.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fphub_acc_initiator;

  localparam int M       = 23;
  localparam int E       = 8;
  localparam int W       = E + M + 1;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             add_start;
  logic [W-1:0]     add_x;
  logic [W-1:0]     add_y;
  logic             add_finish;
  logic [W-1:0]     add_z;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ready = 1'b0;
  logic             busy;
`ifdef FPHUB_ACC_TIMEOUT_EN
  logic             err;
`endif

  fphub_acc_initiator #(
    .M(M), .E(E), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .add_start(add_start), .add_x(add_x), .add_y(add_y),
    .add_finish(add_finish), .add_z(add_z),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count), .out_ready(out_ready),
`ifdef FPHUB_ACC_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder model: finish fin_delay cycles after start rises, Z = X + Y.
  int fin_delay = 2;
  bit fin_never = 1'b0;
  int start_cnt = 0;
  always @(posedge clk) begin
    if (rst || !add_start) start_cnt <= 0;
    else                   start_cnt <= start_cnt + 1;
  end
  assign add_finish = add_start && !fin_never && (start_cnt >= fin_delay);
  assign add_z      = add_x + add_y;

  // Reference state: sum and count of the operands completed in this stream.
  logic [W-1:0] model_acc = '0;
  int           model_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Protocol monitor sampled on the falling edge.
  int           hold_viol = 0;
  int           ready_viol = 0;
  int           start_cycles = 0;
  bit           prev_start = 1'b0;
  logic [W-1:0] prev_x = '0;
  logic [W-1:0] prev_y = '0;
  always @(negedge clk) begin
    if (add_start && prev_start && (add_x !== prev_x || add_y !== prev_y)) hold_viol++;
    if (add_start && in_ready) ready_viol++;
    if (add_start) start_cycles++;
    prev_start = add_start;
    prev_x     = add_x;
    prev_y     = add_y;
  end

  function automatic int exp_count();
    return (model_cnt > CNT_MAX) ? CNT_MAX : model_cnt;
  endfunction

  // Called at a falling edge; returns at the falling edge of the ISSUE cycle.
  task automatic accept(input logic [W-1:0] d, input bit last);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check_eq("accept_bound", 64'(t < 200), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check_eq("issue_start", 64'(add_start), 64'd1);
    check_eq("issue_x", 64'(add_x), 64'(model_acc));
    check_eq("issue_y", 64'(add_y), 64'(d));
  endtask

  task automatic wait_done();
    int t = 0;
    while (add_start && t < 200) begin @(negedge clk); t++; end
    check_eq("finish_bound", 64'(t < 200), 64'd1);
  endtask

  task automatic send_op(input logic [W-1:0] d, input bit last);
    accept(d, last);
    wait_done();
    model_acc = model_acc + d;
    model_cnt++;
  endtask

  task automatic collect(input int hold, input bit exp_err);
    int t = 0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("out_data", 64'(out_data), 64'(model_acc));
    check_eq("out_count", 64'(out_count), 64'(exp_count()));
`ifdef FPHUB_ACC_TIMEOUT_EN
    check_eq("err_in_done", 64'(err), 64'(exp_err));
`else
    if (exp_err) check_eq("err_unexpected", 64'd0, 64'd1);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_data", 64'(out_data), 64'(model_acc));
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("post_valid", 64'(out_valid), 64'd0);
    check_eq("post_in_ready", 64'(in_ready), 64'd1);
`ifdef FPHUB_ACC_TIMEOUT_EN
    check_eq("post_err", 64'(err), 64'd0);
`endif
    model_acc = '0;
    model_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [W-1:0] d;
    int len;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_add_start", 64'(add_start), 64'd0);
    check_eq("rst_add_x", 64'(add_x), 64'd0);
    check_eq("rst_add_y", 64'(add_y), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_count", 64'(out_count), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Single operand, start high ISSUE + two WAIT cycles
    fin_delay = 2;
    s0 = start_cycles;
    send_op(32'h3F80_0000, 1'b1);
    check_eq("single_start_cycles", 64'(start_cycles - s0), 64'd3);
    collect(0, 1'b0);

    // Three operands
    send_op(32'h1, 1'b0);
    send_op(32'h2, 1'b0);
    send_op(32'h4, 1'b1);
    check_eq("three_sum", 64'(model_acc), 64'h7);
    collect(1, 1'b0);

    // Zero-delay finish: two start cycles per operand
    fin_delay = 0;
    s0 = start_cycles;
    send_op(32'h10, 1'b0);
    check_eq("fast_start_cycles", 64'(start_cycles - s0), 64'd2);
    send_op(32'h20, 1'b1);
    collect(0, 1'b0);
    fin_delay = 2;

    // Backpressure with a pending operand that must wait out DONE
    send_op(32'hA, 1'b0);
    send_op(32'hB, 1'b1);
    in_valid = 1'b1; in_data = 32'hC; in_last = 1'b1;
    collect(10, 1'b0);
    check_eq("bp_accept_ready", 64'(in_ready), 64'd1);
    send_op(32'hC, 1'b1);
    collect(0, 1'b0);

    // Count saturation
    for (int k = 0; k < CNT_MAX + 2; k++) send_op(32'h1, k == CNT_MAX + 1);
    check_eq("sat_count_model", 64'(model_cnt), 64'(CNT_MAX + 2));
    collect(0, 1'b0);

    // Reset in the cycle the adder finishes
    accept(32'h55, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_busy_clr", 64'(busy), 64'd0);
    check_eq("mid_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_out_count", 64'(out_count), 64'd0);
    check_eq("mid_out_data", 64'(out_data), 64'd0);
    model_acc = '0;
    model_cnt = 0;
    send_op(32'h77, 1'b1);
    collect(0, 1'b0);

`ifdef FPHUB_ACC_TIMEOUT_EN
    // Watchdog: finish never comes for the second operand
    send_op(32'h10, 1'b0);
    fin_never = 1'b1;
    s0 = start_cycles;
    accept(32'h20, 1'b1);
    wait_done();
    check_eq("wdog_start_cycles", 64'(start_cycles - s0), 64'(TIMEOUT + 1));
    fin_never = 1'b0;
    collect(2, 1'b1);
`endif

    // Randomized streams
    for (int s = 0; s < 25; s++) begin
      len = $urandom_range(1, 6);
      fin_delay = $urandom_range(0, 3);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        d = $urandom;
        send_op(d, k == len - 1);
      end
      collect($urandom_range(0, 3), 1'b0);
    end

    check_eq("hold_violations", 64'(hold_viol), 64'd0);
    check_eq("ready_violations", 64'(ready_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
